// File: rtl/freq_meas_ctrl.sv
// Frequency-measurement sequencer: gated edge counter with a Start/Busy/Done handshake.
// Optional FREQ_CONTINUOUS_EN: back-to-back measurements while Start is held at Done.
module freq_meas_ctrl #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned CNT_W    = 28
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Gate_Sel,
    input  logic             Sig_In,
    output logic             Gate_Signal,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Freq_Count,
    output logic             Overflow
);

    localparam int unsigned GATE_W = $clog2(CLK_FREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GATE  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t              state;
    logic                sync1, sync2, sync3;
    logic                sig_edge_c;
    logic [GATE_W-1:0]   gate_cnt;
    logic [GATE_W-1:0]   gate_last;
    logic [GATE_W-1:0]   gate_last_sel_c;
    logic [CNT_W-1:0]    edge_cnt;
    logic [CNT_W-1:0]    cnt_nxt_c;
    logic                ovf;
    logic                ovf_nxt_c;
    logic                sat_c;

    // Two-flop synchronizer plus one delay flop for rising-edge detection
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= Sig_In;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign sig_edge_c = sync2 & ~sync3;

    // Gate length minus one, so the terminal compare needs no subtractor
    always_comb begin
        gate_last_sel_c = GATE_W'(CLK_FREQ - 1);
        case (Gate_Sel)
            2'd0:    gate_last_sel_c = GATE_W'(CLK_FREQ - 1);
            2'd1:    gate_last_sel_c = GATE_W'(CLK_FREQ / 10 - 1);
            2'd2:    gate_last_sel_c = GATE_W'(CLK_FREQ / 100 - 1);
            default: gate_last_sel_c = GATE_W'(CLK_FREQ / 1000 - 1);
        endcase
    end

    // Saturating count; the next value is also what gets latched on the last gate cycle
    always_comb begin
        sat_c     = &edge_cnt;
        cnt_nxt_c = edge_cnt;
        ovf_nxt_c = ovf;
        if (sig_edge_c) begin
            if (sat_c) begin
                ovf_nxt_c = 1'b1;
            end else begin
                cnt_nxt_c = edge_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= S_IDLE;
            gate_cnt    <= '0;
            gate_last   <= '0;
            edge_cnt    <= '0;
            ovf         <= 1'b0;
            Gate_Signal <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Freq_Count  <= '0;
            Overflow    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state       <= S_GATE;
                        gate_last   <= gate_last_sel_c;
                        gate_cnt    <= '0;
                        edge_cnt    <= '0;
                        ovf         <= 1'b0;
                        Gate_Signal <= 1'b1;
                        Busy        <= 1'b1;
                    end
                end
                S_GATE: begin
                    edge_cnt <= cnt_nxt_c;
                    ovf      <= ovf_nxt_c;
                    if (gate_cnt == gate_last) begin
                        state       <= S_LATCH;
                        Gate_Signal <= 1'b0;
                        Done        <= 1'b1;
                        Freq_Count  <= cnt_nxt_c;
                        Overflow    <= ovf_nxt_c;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                    end
                end
                S_LATCH: begin
`ifdef FREQ_CONTINUOUS_EN
                    if (Start) begin
                        state       <= S_GATE;
                        gate_last   <= gate_last_sel_c;
                        gate_cnt    <= '0;
                        edge_cnt    <= '0;
                        ovf         <= 1'b0;
                        Gate_Signal <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end
`else
                    state <= S_IDLE;
                    Busy  <= 1'b0;
`endif
                end
                default: begin
                    state       <= S_IDLE;
                    Gate_Signal <= 1'b0;
                    Busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with CLK_FREQ=100_000 (1ms gate = 100 cycles).
// A second instance with CNT_W=4 shares all inputs to exercise saturation.
module tb_freq_meas_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Gate_Sel = 2'd3;
    logic        Sig_In = 1'b0;

    logic        Gate_Signal, Busy, Done, Overflow;
    logic [27:0] Freq_Count;
    logic        Gate_Signal4, Busy4, Done4, Overflow4;
    logic [3:0]  Freq_Count4;

    int ncmp = 0;
    int nerr = 0;

    // Per-run observations
    int gfirst, glast, ghigh, ndone, blow;
    int dn [4];
    logic [27:0] fc;
    logic        ov;
    logic [3:0]  fc4;
    logic        ov4;
    int          extra_done;

    freq_meas_ctrl #(.CLK_FREQ(100_000), .CNT_W(28)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Gate_Sel(Gate_Sel), .Sig_In(Sig_In),
        .Gate_Signal(Gate_Signal), .Busy(Busy), .Done(Done),
        .Freq_Count(Freq_Count), .Overflow(Overflow)
    );

    freq_meas_ctrl #(.CLK_FREQ(100_000), .CNT_W(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Gate_Sel(Gate_Sel), .Sig_In(Sig_In),
        .Gate_Signal(Gate_Signal4), .Busy(Busy4), .Done(Done4),
        .Freq_Count(Freq_Count4), .Overflow(Overflow4)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Start=1 in cycle 0 (current cycle); Start also high for cycles <= hold_end and at st_a/st_b/st_c.
    // Sig_In: square wave of given period with first rise at cycle 'first' (period 0 = idle).
    task automatic run(input logic [1:0] gsel, input int period, input int first,
                       input int hold_end, input int st_a, input int st_b, input int st_c,
                       input int ncyc, input bit flip_sel);
        gfirst = -1; glast = -1; ghigh = 0; ndone = 0; blow = -1;
        for (int i = 0; i < 4; i++) dn[i] = -1;
        fc = '1; ov = 1'bx; fc4 = '1; ov4 = 1'bx;
        Gate_Sel = gsel;
        Sig_In   = 1'b0;
        Start    = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            Start = (c <= hold_end) || (c == st_a) || (c == st_b) || (c == st_c);
            if (flip_sel && c == 10) Gate_Sel = ~gsel;
            if (period > 0 && c >= first && ((c - first) % period) < (period / 2))
                Sig_In = 1'b1;
            else
                Sig_In = 1'b0;
            if (Gate_Signal) begin
                if (gfirst < 0) gfirst = c;
                glast = c;
                ghigh++;
            end
            if (Done) begin
                if (ndone == 0) begin
                    fc  = Freq_Count;
                    ov  = Overflow;
                    fc4 = Freq_Count4;
                    ov4 = Overflow4;
                end
                if (ndone < 4) dn[ndone] = c;
                ndone++;
            end
            if (ndone > 0 && !Busy && blow < 0) blow = c;
        end
        Start  = 1'b0;
        Sig_In = 1'b0;
    endtask

    initial begin
        // Reset state
        idle(3);
        Rst_n = 1'b1;
        idle(2);
        chk("rst_gate",   64'(Gate_Signal), 64'd0);
        chk("rst_busy",   64'(Busy),        64'd0);
        chk("rst_done",   64'(Done),        64'd0);
        chk("rst_count",  64'(Freq_Count),  64'd0);
        chk("rst_ovf",    64'(Overflow),    64'd0);

        // 1ms gate, period 10 from cycle 5; Gate_Sel flipped mid-gate must not matter
        run(2'd3, 10, 5, 0, -1, -1, -1, 110, 1'b1);
        chk("t1_gate_first", 64'(gfirst), 64'd1);
        chk("t1_gate_last",  64'(glast),  64'd100);
        chk("t1_gate_high",  64'(ghigh),  64'd100);
        chk("t1_ndone",      64'(ndone),  64'd1);
        chk("t1_done_cyc",   64'(dn[0]),  64'd101);
        chk("t1_count",      64'(fc),     64'd10);
        chk("t1_ovf",        64'(ov),     64'd0);
        chk("t1_busy_low",   64'(blow),   64'd102);
        chk("t1_count_held", 64'(Freq_Count), 64'd10);

        // 10ms gate, period 7
        idle(5);
        run(2'd2, 7, 5, 0, -1, -1, -1, 1010, 1'b0);
        chk("t2_count",     64'(fc),    64'd142);
        chk("t2_done_cyc",  64'(dn[0]), 64'd1001);
        chk("t2_busy_low",  64'(blow),  64'd1002);
        chk("t2_ndone",     64'(ndone), 64'd1);

        // 25 edges: wide counter exact, 4-bit counter saturates
        idle(5);
        run(2'd3, 4, 1, 0, -1, -1, -1, 110, 1'b0);
        chk("t3_count28", 64'(fc),  64'd25);
        chk("t3_ovf28",   64'(ov),  64'd0);
        chk("t3_count4",  64'(fc4), 64'd15);
        chk("t3_ovf4",    64'(ov4), 64'd1);

        // Idle signal clears count and overflow
        idle(5);
        run(2'd3, 0, 0, 0, -1, -1, -1, 110, 1'b0);
        chk("t3b_count28", 64'(fc),  64'd0);
        chk("t3b_count4",  64'(fc4), 64'd0);
        chk("t3b_ovf4",    64'(ov4), 64'd0);

        // Start re-pulsed during the measurement, then at the earliest re-accept cycle
        idle(5);
        run(2'd3, 10, 5, 0, 50, 101, 102, 210, 1'b0);
        chk("t4_ndone",    64'(ndone), 64'd2);
        chk("t4_done0",    64'(dn[0]), 64'd101);
        chk("t4_count",    64'(fc),    64'd10);
`ifdef FREQ_CONTINUOUS_EN
        chk("t4_done1",    64'(dn[1]), 64'd202);
`else
        chk("t4_done1",    64'(dn[1]), 64'd203);
`endif

        // Reset at cycle 40 of a gate
        idle(5);
        run(2'd3, 10, 5, 0, -1, -1, -1, 40, 1'b0);
        chk("t5_gate_before", 64'(Gate_Signal), 64'd1);
        chk("t5_count_before", 64'(Freq_Count), 64'd10);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("t5_gate_rst",  64'(Gate_Signal), 64'd0);
        chk("t5_busy_rst",  64'(Busy),        64'd0);
        chk("t5_count_rst", 64'(Freq_Count),  64'd0);
        tick();
        Rst_n = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (Done || Gate_Signal) extra_done++;
        end
        chk("t5_no_done", 64'(extra_done), 64'd0);
        run(2'd3, 10, 5, 0, -1, -1, -1, 110, 1'b0);
        chk("t5_after_done", 64'(dn[0]), 64'd101);
        chk("t5_after_count", 64'(fc),   64'd10);

        // Start held high across several gate lengths
        idle(5);
`ifdef FREQ_CONTINUOUS_EN
        run(2'd3, 10, 5, 249, -1, -1, -1, 320, 1'b0);
        chk("t6_ndone",    64'(ndone), 64'd3);
        chk("t6_done0",    64'(dn[0]), 64'd101);
        chk("t6_done1",    64'(dn[1]), 64'd202);
        chk("t6_done2",    64'(dn[2]), 64'd303);
        chk("t6_gate_lows", 64'(glast - gfirst + 1 - ghigh), 64'd2);
        chk("t6_gate_last", 64'(glast), 64'd302);
        chk("t6_busy_low", 64'(blow),  64'd304);
        chk("t6_count",    64'(Freq_Count), 64'd10);
`else
        run(2'd3, 10, 5, 150, -1, -1, -1, 220, 1'b0);
        chk("t6_ndone",    64'(ndone), 64'd2);
        chk("t6_done0",    64'(dn[0]), 64'd101);
        chk("t6_done1",    64'(dn[1]), 64'd203);
        chk("t6_gate_lows", 64'(glast - gfirst + 1 - ghigh), 64'd2);
        chk("t6_gate_last", 64'(glast), 64'd202);
        chk("t6_busy_low", 64'(blow),  64'd102);
        chk("t6_count",    64'(Freq_Count), 64'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
